// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory bus arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  localparam logic PORT_INSTR = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  bhw;
    logic        we;
  } mem_req_t;

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-way round-robin picker: with both ports requesting, the port that was
// not granted last wins; a lone request always wins.
module mem_arb_rr2
  import mem_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    if (i_req[0] && (!i_req[1] || i_last == PORT_DATA))  o_grant[0] = 1'b1;
    if (i_req[1] && (!i_req[0] || i_last == PORT_INSTR)) o_grant[1] = 1'b1;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master (instr/data) arbiter onto a single-outstanding memory port.
// Optional WAIT timeout enabled by defining MEM_ARB_TIMEOUT_EN.
//
// state    | meaning
// IDLE     | no transaction; arbitrate and latch winner fields
// ISSUE    | o_mem_DV pulse to the memory controller
// WAIT     | waiting for i_mem_DV (or timeout when enabled)
// DONE     | ack (and err) pulse to the winning master
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_m0_req,
  input  logic [31:0] i_m0_addr,
  input  logic [31:0] i_m0_wdata,
  input  logic [2:0]  i_m0_bhw,
  input  logic        i_m0_we,
  output logic [31:0] o_m0_rdata,
  output logic        o_m0_ack,
  output logic        o_m0_err,
  input  logic        i_m1_req,
  input  logic [31:0] i_m1_addr,
  input  logic [31:0] i_m1_wdata,
  input  logic [2:0]  i_m1_bhw,
  input  logic        i_m1_we,
  output logic [31:0] o_m1_rdata,
  output logic        o_m1_ack,
  output logic        o_m1_err,
  output logic [31:0] o_mem_data,
  output logic [31:0] o_mem_address,
  output logic [2:0]  o_mem_bhw,
  output logic        o_mem_write_notread,
  output logic        o_mem_DV,
  input  logic [31:0] i_mem_data,
  input  logic        i_mem_DV,
  output logic        o_busy
);

  arb_state_e  state_q, state_d;
  logic        last_q, last_d;
  mem_req_t    mem_q, mem_d;
  logic        mem_dv_q, mem_dv_d;
  logic [1:0]  ack_q, ack_d, err_q, err_d;
  logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic [1:0]  grant;
  mem_req_t    req0, req1, win;
  logic        fin, fin_err;
  logic [31:0] fin_data;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0] tmo_q, tmo_d;
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES == 32'd0);
`endif

  assign req0 = {i_m0_addr, i_m0_wdata, i_m0_bhw, i_m0_we};
  assign req1 = {i_m1_addr, i_m1_wdata, i_m1_bhw, i_m1_we};

  mem_arb_rr2 u_rr2 (
    .i_req   ({i_m1_req, i_m0_req}),
    .i_last  (last_q),
    .o_grant (grant)
  );

  assign win = grant[1] ? req1 : req0;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    mem_d    = mem_q;
    mem_dv_d = 1'b0;
    ack_d    = 2'b00;
    err_d    = 2'b00;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    fin      = 1'b0;
    fin_err  = 1'b0;
    fin_data = '0;
`ifdef MEM_ARB_TIMEOUT_EN
    tmo_d    = tmo_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          last_d = grant[1];
          mem_d  = win;
          // zero-byte requests never reach memory and complete as errors
          if (win.bhw == 3'd0) begin
            state_d  = ST_DONE;
            fin      = 1'b1;
            fin_err  = 1'b1;
            fin_data = ERR_DATA;
          end else begin
            state_d  = ST_ISSUE;
            mem_dv_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
`ifdef MEM_ARB_TIMEOUT_EN
        tmo_d   = TMO_W'(TIMEOUT_CYCLES - 1);
`endif
      end
      ST_WAIT: begin
        if (i_mem_DV) begin
          state_d  = ST_DONE;
          fin      = 1'b1;
          fin_data = mem_q.we ? '0 : i_mem_data;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (tmo_q == '0) begin
          state_d  = ST_DONE;
          fin      = 1'b1;
          fin_err  = 1'b1;
          fin_data = ERR_DATA;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (fin) begin
      if (last_d == PORT_DATA) begin
        ack_d[1] = 1'b1;
        err_d[1] = fin_err;
        rdata1_d = fin_data;
      end else begin
        ack_d[0] = 1'b1;
        err_d[0] = fin_err;
        rdata0_d = fin_data;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      last_q   <= PORT_INSTR;
      mem_q    <= '0;
      mem_dv_q <= 1'b0;
      ack_q    <= 2'b00;
      err_q    <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      tmo_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      mem_q    <= mem_d;
      mem_dv_q <= mem_dv_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
`ifdef MEM_ARB_TIMEOUT_EN
      tmo_q    <= tmo_d;
`endif
    end
  end

  assign o_m0_rdata          = rdata0_q;
  assign o_m0_ack            = ack_q[0];
  assign o_m0_err            = err_q[0];
  assign o_m1_rdata          = rdata1_q;
  assign o_m1_ack            = ack_q[1];
  assign o_m1_err            = err_q[1];
  assign o_mem_data          = mem_q.wdata;
  assign o_mem_address       = mem_q.addr;
  assign o_mem_bhw           = mem_q.bhw;
  assign o_mem_write_notread = mem_q.we;
  assign o_mem_DV            = mem_dv_q;
  assign o_busy              = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_mem_bus_arbiter;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int DUT_TMO = 16;
`else
  localparam int DUT_TMO = 1024;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic [2:0]  m0_bhw = '0, m1_bhw = '0;
  logic [31:0] mem_rdata = '0;
  logic        mem_dv_in = 1'b0;
  logic [31:0] m0_rdata, m1_rdata, mem_wdata, mem_addr;
  logic        m0_ack, m0_err, m1_ack, m1_err, mem_wnr, mem_dv, busy;
  logic [2:0]  mem_bhw;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(DUT_TMO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_m0_req(m0_req), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
    .i_m0_bhw(m0_bhw), .i_m0_we(m0_we),
    .o_m0_rdata(m0_rdata), .o_m0_ack(m0_ack), .o_m0_err(m0_err),
    .i_m1_req(m1_req), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
    .i_m1_bhw(m1_bhw), .i_m1_we(m1_we),
    .o_m1_rdata(m1_rdata), .o_m1_ack(m1_ack), .o_m1_err(m1_err),
    .o_mem_data(mem_wdata), .o_mem_address(mem_addr), .o_mem_bhw(mem_bhw),
    .o_mem_write_notread(mem_wnr), .o_mem_DV(mem_dv),
    .i_mem_data(mem_rdata), .i_mem_DV(mem_dv_in),
    .o_busy(busy)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: timestamps of grant and completion, not a state machine.
  int          edge_n = 0, g_edge = 0, d_edge = 0;
  bit          in_txn = 0, completed = 0, m_port = 0, last_port = 0;
  logic [31:0] e_rdata0, e_rdata1, e_maddr, e_mdata;
  logic        e_ack0, e_err0, e_ack1, e_err1, e_mwnr, e_mdv, e_busy;
  logic [2:0]  e_mbhw;
  int          mem_cnt = -1;

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic logic [137:0] dut_vec();
    return {m0_rdata, m0_ack, m0_err, m1_rdata, m1_ack, m1_err,
            mem_wdata, mem_addr, mem_bhw, mem_wnr, mem_dv, busy};
  endfunction

  task automatic model_reset();
    in_txn = 0; completed = 0; last_port = 0;
    e_rdata0 = '0; e_rdata1 = '0; e_maddr = '0; e_mdata = '0; e_mbhw = '0;
    e_ack0 = 0; e_err0 = 0; e_ack1 = 0; e_err1 = 0; e_mwnr = 0; e_mdv = 0; e_busy = 0;
  endtask

  task automatic finish_txn(input logic [31:0] data, input logic err);
    completed = 1;
    d_edge    = edge_n;
    if (m_port) begin e_ack1 = 1; e_err1 = err; e_rdata1 = data; end
    else        begin e_ack0 = 1; e_err0 = err; e_rdata0 = data; end
  endtask

  // Predicts the outputs seen after the coming rising edge from current inputs.
  task automatic model_step();
    e_ack0 = 0; e_err0 = 0; e_ack1 = 0; e_err1 = 0; e_mdv = 0;
    if (in_txn && completed && edge_n == d_edge + 1) begin
      in_txn = 0;
    end else if (!in_txn) begin
      if (m0_req || m1_req) begin
        m_port    = (m0_req && m1_req) ? !last_port : m1_req;
        last_port = m_port;
        in_txn    = 1;
        completed = 0;
        g_edge    = edge_n;
        e_maddr   = m_port ? m1_addr  : m0_addr;
        e_mdata   = m_port ? m1_wdata : m0_wdata;
        e_mbhw    = m_port ? m1_bhw   : m0_bhw;
        e_mwnr    = m_port ? m1_we    : m0_we;
        if (e_mbhw == 3'd0) finish_txn(32'hDEADBEEF, 1'b1);
        else e_mdv = 1;
      end
    end else if (!completed) begin
      if (edge_n >= g_edge + 2 && mem_dv_in) finish_txn(e_mwnr ? 32'h0 : mem_rdata, 1'b0);
`ifdef MEM_ARB_TIMEOUT_EN
      else if (edge_n == g_edge + 1 + DUT_TMO) finish_txn(32'hDEADBEEF, 1'b1);
`endif
    end
    e_busy = in_txn;
    edge_n++;
  endtask

  task automatic compare();
    logic [137:0] a, e;
    a = dut_vec();
    e = {e_rdata0, e_ack0, e_err0, e_rdata1, e_ack1, e_err1,
         e_mdata, e_maddr, e_mbhw, e_mwnr, e_mdv, e_busy};
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL cycle_check edge %0d: got %h want %h", edge_n, a, e);
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  // Memory responder: answers lat cycles after it sees the issue pulse.
  task automatic mem_tick(input int lat, input logic [31:0] data);
    mem_dv_in = 1'b0;
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        mem_dv_in = 1'b1;
        mem_rdata = data;
        mem_cnt   = -1;
      end
    end else if (mem_dv) begin
      mem_cnt = lat;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    m0_req = 0; m1_req = 0; mem_dv_in = 0; mem_cnt = -1;
    repeat (2) @(negedge clk);
    lit("reset_outputs_zero", {31'd0, (dut_vec() != '0)}, 32'd0);
    model_reset();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int          ack_cyc, dv_cnt;
    logic [31:0] got;
    int          order[$];
    int          want_seq[4];

    // m1 read, memory answers 5 cycles after issue; grant cycle counts as 1
    apply_reset();
    m1_req = 1; m1_addr = 32'h100; m1_bhw = 3'd4; m1_we = 0; m1_wdata = 32'h0;
    ack_cyc = 0; dv_cnt = 0; got = '0;
    for (int s = 1; s <= 40; s++) begin
      step();
      if (mem_dv) dv_cnt++;
      if (m1_ack && ack_cyc == 0) begin ack_cyc = s + 1; got = m1_rdata; m1_req = 0; end
      mem_tick(5, 32'h12345678);
      if (ack_cyc != 0 && s > ack_cyc + 2) break;
    end
    lit("t1_dv_count", dv_cnt, 32'd1);
    lit("t1_ack_cycle", ack_cyc, 32'd8);
    lit("t1_rdata", got, 32'h12345678);

    // contention from reset alternates m1, m0, m1, m0
    apply_reset();
    want_seq = '{1, 0, 1, 0};
    m0_req = 1; m0_addr = 32'h10; m0_bhw = 3'd4; m0_we = 0;
    m1_req = 1; m1_addr = 32'h20; m1_bhw = 3'd4; m1_we = 0;
    for (int s = 0; s < 100 && order.size() < 4; s++) begin
      step();
      if (m0_ack) order.push_back(0);
      if (m1_ack) order.push_back(1);
      mem_tick(2, $urandom);
    end
    m0_req = 0; m1_req = 0;
    for (int i = 0; i < 4; i++)
      lit($sformatf("t2_winner%0d", i), (i < order.size()) ? order[i] : 99, want_seq[i]);

    // m0 write: exact fields on the memory side, zero read data
    apply_reset();
    m0_req = 1; m0_addr = 32'h2000; m0_wdata = 32'hAABBCCDD; m0_bhw = 3'd2; m0_we = 1;
    ack_cyc = 0;
    for (int s = 1; s <= 40 && ack_cyc == 0; s++) begin
      step();
      if (s == 1) begin
        lit("t3_addr", mem_addr, 32'h2000);
        lit("t3_data", mem_wdata, 32'hAABBCCDD);
        lit("t3_bhw", {29'd0, mem_bhw}, 32'd2);
        lit("t3_wnr", {31'd0, mem_wnr}, 32'd1);
      end
      if (m0_ack) begin
        ack_cyc = s + 1;
        m0_req  = 0;
        lit("t3_rdata", m0_rdata, 32'h0);
        lit("t3_addr_in_done", mem_addr, 32'h2000);
      end
      mem_tick(3, 32'h5A5A1234);
    end
    lit("t3_acked", {31'd0, (ack_cyc != 0)}, 32'd1);
    mem_dv_in = 0;
    step();

    // stray memory completions while idle
    for (int s = 0; s < 3; s++) begin
      mem_dv_in = 1; mem_rdata = $urandom;
      step();
      lit("t4_stray_busy", {31'd0, busy}, 32'd0);
      lit("t4_stray_ack", {30'd0, m1_ack, m0_ack}, 32'd0);
    end
    mem_dv_in = 0;

    // zero-byte request: error ack two cycles after grant, no memory issue
    m1_req = 1; m1_addr = 32'h44; m1_bhw = 3'd0; m1_we = 0;
    ack_cyc = 0; dv_cnt = 0; got = '0;
    for (int s = 1; s <= 6; s++) begin
      step();
      if (mem_dv) dv_cnt++;
      if (m1_ack && ack_cyc == 0) begin ack_cyc = s + 1; got = {31'd0, m1_err}; m1_req = 0; end
    end
    lit("t4_bhw0_ack_cycle", ack_cyc, 32'd2);
    lit("t4_bhw0_err", got, 32'd1);
    lit("t4_bhw0_dv_count", dv_cnt, 32'd0);

    // reset while waiting on memory
    m0_req = 1; m0_addr = 32'h300; m0_bhw = 3'd4; m0_we = 0;
    step();
    step();
    lit("t5_busy_before_reset", {31'd0, busy}, 32'd1);
    m0_req = 0;
    #2 rst = 1'b1;
    #1 lit("t5_outputs_zero", {31'd0, (dut_vec() != '0)}, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    mem_dv_in = 1; mem_rdata = 32'h77777777;
    step();
    mem_dv_in = 0;
    lit("t5_no_ack_after_reset", {30'd0, m1_ack, m0_ack}, 32'd0);
    m1_req = 1; m1_addr = 32'h400; m1_bhw = 3'd4; m1_we = 0;
    got = '0; ack_cyc = 0;
    for (int s = 1; s <= 30 && ack_cyc == 0; s++) begin
      step();
      if (m1_ack) begin ack_cyc = s + 1; got = m1_rdata; m1_req = 0; end
      mem_tick(2, 32'hCAFE0001);
    end
    lit("t5_next_rdata", got, 32'hCAFE0001);
    lit("t5_next_ack_cycle", ack_cyc, 32'd5);

`ifdef MEM_ARB_TIMEOUT_EN
    // silent memory: error ack after 16 WAIT cycles
    apply_reset();
    m0_req = 1; m0_addr = 32'h500; m0_bhw = 3'd4; m0_we = 0;
    ack_cyc = 0; got = '0;
    for (int s = 1; s <= 40 && ack_cyc == 0; s++) begin
      step();
      if (m0_ack) begin
        ack_cyc = s + 1; got = m0_rdata; m0_req = 0;
        lit("t6_err", {31'd0, m0_err}, 32'd1);
      end
    end
    lit("t6_ack_cycle", ack_cyc, 32'd19);
    lit("t6_rdata", got, 32'hDEADBEEF);
`endif

    // random traffic against the model
    apply_reset();
    for (int n = 0; n < 3000; n++) begin
      if (!m0_req) begin
        if ($urandom_range(0, 2) == 0) begin
          m0_req = 1; m0_addr = $urandom; m0_wdata = $urandom; m0_we = $urandom_range(0, 1);
          m0_bhw = ($urandom_range(0, 9) == 0) ? 3'd0 : 3'($urandom_range(1, 4));
        end
      end else if ($urandom_range(0, 39) == 0) m0_req = 0;
      if (!m1_req) begin
        if ($urandom_range(0, 2) == 0) begin
          m1_req = 1; m1_addr = $urandom; m1_wdata = $urandom; m1_we = $urandom_range(0, 1);
          m1_bhw = ($urandom_range(0, 9) == 0) ? 3'd0 : 3'($urandom_range(1, 4));
        end
      end else if ($urandom_range(0, 39) == 0) m1_req = 0;
      mem_dv_in = ($urandom_range(0, 5) == 0);
      mem_rdata = $urandom;
      step();
      if (m0_ack) m0_req = 0;
      if (m1_ack) m1_req = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
